// File: rtl/tx_fifo_byte_serializer_pkg.sv
// Shared state encoding and sizing helpers for the TX FIFO byte serializer.
package tx_fifo_byte_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam int W_DATA_DEF     = 256;
   localparam int W_BYTE_DEF     = 8;
   localparam int BYTES_PER_WORD = W_DATA_DEF / W_BYTE_DEF;
   localparam int IDX_W_DEF      = $clog2(BYTES_PER_WORD);
   localparam int LAT_W          = 2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_fifo_byte_serializer.sv
// Drains one FIFO word at a time and streams it LSB byte first
// over a valid/ready byte handshake towards the UART transmitter.
module tx_fifo_byte_serializer
   import tx_fifo_byte_serializer_pkg::*;
#(
   parameter int W_DATA = 256,
   parameter int W_BYTE = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_fifo_empty,
   input  logic [W_DATA-1:0] i_fifo_rdata,
   output logic              o_fifo_rd_en,
   output logic [W_BYTE-1:0] o_byte,
   output logic              o_byte_valid,
   input  logic              i_byte_ready,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_word_cnt
);

   localparam int BPW   = W_DATA / W_BYTE;
   localparam int IDX_W = idx_width(BPW);

   state_t             state_q;
   state_t             state_d;
   logic [W_DATA-1:0]  sreg;
   logic [W_DATA-1:0]  sreg_nxt;
   logic [IDX_W-1:0]   byte_idx;
   logic [LAT_W-1:0]   lat_cnt;
   logic               xfer;
   logic               last_byte;
   logic               lat_last;
   logic               pop;

   assign sreg_nxt  = sreg >> W_BYTE;
   assign xfer      = o_byte_valid && i_byte_ready;
   assign last_byte = (byte_idx == IDX_W'(BPW - 1));
   assign lat_last  = (lat_cnt == LAT_W'(1));
   assign pop       = (state_q == IDLE) && !i_fifo_empty;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!i_fifo_empty) state_d = WAIT;
         WAIT: if (lat_last) state_d = SEND;
         SEND: if (xfer && last_byte) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Data lands on the edge RD_LAT cycles after the pop strobe rises,
   // so WAIT lasts exactly RD_LAT cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fifo_rd_en <= 1'b0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
         o_word_cnt   <= '0;
         sreg         <= '0;
         byte_idx     <= '0;
         lat_cnt      <= '0;
      end else begin
         o_fifo_rd_en <= pop;
         unique case (state_q)
            IDLE: begin
               if (pop) lat_cnt <= LAT_W'(RD_LAT);
            end
            WAIT: begin
               lat_cnt <= lat_cnt - LAT_W'(1);
               if (lat_last) begin
                  sreg         <= i_fifo_rdata;
                  o_byte       <= i_fifo_rdata[W_BYTE-1:0];
                  o_byte_valid <= 1'b1;
                  byte_idx     <= '0;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (last_byte) begin
                     o_byte_valid <= 1'b0;
                     o_word_cnt   <= o_word_cnt + CNT_W'(1);
                  end else begin
                     sreg     <= sreg_nxt;
                     o_byte   <= sreg_nxt[W_BYTE-1:0];
                     byte_idx <= byte_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               o_byte_valid <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      o_busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_tx_fifo_byte_serializer.sv
// Directed, table-driven bench for tx_fifo_byte_serializer
// with a small FIFO model and a byte/strobe monitor.
module tb_tx_fifo_byte_serializer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         fifo_empty;
   logic [255:0] fifo_rdata;
   logic         rd_en;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic         byte_ready = 1'b0;
   logic         busy;
   logic [15:0]  word_cnt;

   logic [255:0] mem [16];
   logic [4:0]   wptr = '0;
   logic [4:0]   rptr = '0;

   int checks = 0;
   int errors = 0;

   tx_fifo_byte_serializer #(
      .W_DATA(256), .W_BYTE(8), .RD_LAT(1), .CNT_W(16)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_fifo_empty (fifo_empty),
      .i_fifo_rdata (fifo_rdata),
      .o_fifo_rd_en (rd_en),
      .o_byte       (byte_out),
      .o_byte_valid (byte_valid),
      .i_byte_ready (byte_ready),
      .o_busy       (busy),
      .o_word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   // Head word is visible on rdata; a sampled pop advances the read pointer.
   assign fifo_empty = (rptr == wptr);
   assign fifo_rdata = mem[rptr[3:0]];
   always @(posedge clk) if (rd_en) rptr <= rptr + 5'd1;

   int         cyc = 0;
   int         rd_pulses = 0;
   int         double_rd = 0;
   int         rd_empty = 0;
   int         stall_err = 0;
   int         low_run = 100;
   int         rd_cyc_q[$];
   int         rise_cyc_q[$];
   int         gap_q[$];
   int         xfer_cyc_q[$];
   logic [7:0] got_q[$];
   bit         valid_prev = 0;
   bit         rd_prev = 0;
   bit         stall_prev = 0;
   logic [7:0] byte_prev = '0;

   always @(negedge clk) begin
      cyc++;
      if (rd_en) begin
         rd_pulses++;
         rd_cyc_q.push_back(cyc);
         if (rd_prev) double_rd++;
         if (fifo_empty) rd_empty++;
      end
      if (byte_valid && !valid_prev) begin
         rise_cyc_q.push_back(cyc);
         gap_q.push_back(low_run);
      end
      low_run = byte_valid ? 0 : low_run + 1;
      if (stall_prev && (!byte_valid || byte_out != byte_prev)) stall_err++;
      if (byte_valid && byte_ready) begin
         got_q.push_back(byte_out);
         xfer_cyc_q.push_back(cyc);
      end
      stall_prev = byte_valid && !byte_ready;
      byte_prev  = byte_out;
      valid_prev = byte_valid;
      rd_prev    = rd_en;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic push(input logic [255:0] w);
      mem[wptr[3:0]] = w;
      wptr = wptr + 5'd1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      byte_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_until(input int nbytes, input int b0, input bit stall,
                            input bit need_idle, output bit ok);
      bit ph = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 800; n++) begin
         byte_ready = stall ? ph : 1'b1;
         ph = ~ph;
         @(posedge clk); #1;
         if ((got_q.size() - b0 >= nbytes) && (!need_idle || !busy)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      int              nw;
      logic [2:0][255:0] w;
      bit              stall;
      int              exp_pulses;
      int              exp_cnt;
   } vec_t;

   vec_t         tv[3];
   logic [255:0] cw;
   logic [255:0] wv;
   logic [7:0]   eb;
   int           b0, p0, r0, s0, d0, e0, nb;
   bit           ok;
   bit           bad_valid, bad_busy, bad_cnt;

   initial begin
      for (int k = 0; k < 32; k++) cw[8*k +: 8] = k[7:0];
      tv[0].nw = 1; tv[0].w = '0; tv[0].w[0] = cw;
      tv[0].stall = 0; tv[0].exp_pulses = 1; tv[0].exp_cnt = 1;
      tv[1].nw = 1; tv[1].w = '0; tv[1].w[0] = cw;
      tv[1].stall = 1; tv[1].exp_pulses = 1; tv[1].exp_cnt = 1;
      tv[2].nw = 3; tv[2].w = '0;
      tv[2].w[0] = {32{8'hAA}};
      tv[2].w[1] = {32{8'h55}};
      tv[2].w[2] = {32{8'h0F}};
      tv[2].stall = 0; tv[2].exp_pulses = 3; tv[2].exp_cnt = 3;

      // Reset held, then idle with an empty FIFO
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", byte_valid, 0);
      chk("rst_byte", byte_out, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", word_cnt, 0);
      rst = 1'b0;
      p0 = rd_pulses;
      bad_valid = 0; bad_busy = 0; bad_cnt = 0;
      byte_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bad_valid |= byte_valid;
         bad_busy  |= busy;
         bad_cnt   |= (word_cnt != 0);
      end
      chk("idle_rd_pulses", rd_pulses - p0, 0);
      chk("idle_valid", bad_valid, 0);
      chk("idle_busy", bad_busy, 0);
      chk("idle_cnt", bad_cnt, 0);

      for (int t = 0; t < 3; t++) begin
         do_reset();
         b0 = got_q.size(); p0 = rd_cyc_q.size(); r0 = rise_cyc_q.size();
         s0 = stall_err; d0 = double_rd; e0 = rd_empty;
         nb = 32 * tv[t].nw;
         for (int i = 0; i < tv[t].nw; i++) push(tv[t].w[i]);
         run_until(nb, b0, tv[t].stall, 1'b1, ok);
         chk($sformatf("v%0d_done", t), ok, 1);
         repeat (5) @(posedge clk);
         #1;
         chk($sformatf("v%0d_nbytes", t), got_q.size() - b0, nb);
         for (int j = 0; j < nb; j++) begin
            wv = tv[t].w[j / 32];
            eb = wv[8*(j % 32) +: 8];
            if (b0 + j < got_q.size())
               chk($sformatf("v%0d_byte%0d", t, j), got_q[b0 + j], eb);
         end
         chk($sformatf("v%0d_pulses", t), rd_cyc_q.size() - p0, tv[t].exp_pulses);
         chk($sformatf("v%0d_cnt", t), word_cnt, tv[t].exp_cnt);
         chk($sformatf("v%0d_busy", t), busy, 0);
         chk($sformatf("v%0d_stall_stable", t), stall_err - s0, 0);
         chk($sformatf("v%0d_rd_double", t), double_rd - d0, 0);
         chk($sformatf("v%0d_rd_empty", t), rd_empty - e0, 0);
         if (t == 0) begin
            chk("v0_rd_to_valid",
                (rise_cyc_q.size() > r0 && rd_cyc_q.size() > p0) ?
                rise_cyc_q[r0] - rd_cyc_q[p0] : -1, 1);
            chk("v0_consecutive",
                (xfer_cyc_q.size() >= b0 + 32) ?
                xfer_cyc_q[b0 + 31] - xfer_cyc_q[b0] : -1, 31);
         end
         if (t == 2) begin
            chk("v2_gap1", (gap_q.size() > r0 + 1) ? gap_q[r0 + 1] : -1, 2);
            chk("v2_gap2", (gap_q.size() > r0 + 2) ? gap_q[r0 + 2] : -1, 2);
            chk("v2_period",
                (rd_cyc_q.size() > p0 + 1) ?
                rd_cyc_q[p0 + 1] - rd_cyc_q[p0] : -1, 34);
         end
      end

      // Empty boundary: single word, idle right after byte 31
      do_reset();
      b0 = got_q.size(); p0 = rd_pulses;
      push(cw);
      run_until(32, b0, 1'b0, 1'b0, ok);
      chk("eb_done", ok, 1);
      chk("eb_busy_after_last", busy, 0);
      chk("eb_valid_after_last", byte_valid, 0);
      chk("eb_last_byte", (got_q.size() >= b0 + 32) ? got_q[b0 + 31] : -1, 8'h1F);
      repeat (10) @(posedge clk);
      #1;
      chk("eb_pulses", rd_pulses - p0, 1);
      chk("eb_empty", fifo_empty, 1);

      // Reset mid-word, right after byte 10 is accepted
      do_reset();
      b0 = got_q.size(); p0 = rd_pulses;
      push(cw);
      run_until(11, b0, 1'b0, 1'b0, ok);
      chk("mr_reach_b10", ok, 1);
      rst = 1'b1;
      #1;
      chk("mr_valid", byte_valid, 0);
      chk("mr_busy", busy, 0);
      chk("mr_cnt", word_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mr_nbytes", got_q.size() - b0, 11);
      chk("mr_pulses", rd_pulses - p0, 1);
      chk("mr_byte10", (got_q.size() >= b0 + 11) ? got_q[b0 + 10] : -1, 8'h0A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
